// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute-stage multiply/divide unit:
// operation encodings, FSM states, iteration count and sign helpers.
package mips_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_NOP0  = 3'b110,
        OP_NOP1  = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    localparam int MULDIV_ITERS = 32;

    // Counter value of the final radix-2 step.
    localparam logic [5:0] MULDIV_LAST_ITER = 6'(MULDIV_ITERS - 1);

    // Two's-complement negate a 32-bit value when neg is set.
    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        logic [31:0] r;
        if (neg) begin
            r = (~v) + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's-complement negate a 64-bit value when neg is set.
    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
        logic [63:0] r;
        if (neg) begin
            r = (~v) + 64'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// Multiply: shift-add, multiplier bits consumed LSB first from sh_i,
//           product high half in acc, low half shifted into sh.
// Divide:   restoring division, dividend bits consumed MSB first from sh_i,
//           quotient bits shifted into sh, partial remainder in acc.
module muldiv_step
    import mips_pkg::*;
(
    input  logic        is_div,
    input  logic [32:0] acc_i,
    input  logic [31:0] sh_i,
    input  logic [31:0] operand_i,
    output logic [32:0] acc_o,
    output logic [31:0] sh_o
);

    logic [31:0] addend_s;
    logic [32:0] sum_s;
    logic [32:0] shifted_s;
    logic [33:0] diff_s;

    // Compute both candidate step results and select by operation.
    always_comb begin
        if (sh_i[0]) begin
            addend_s = operand_i;
        end else begin
            addend_s = 32'd0;
        end
        // acc_i[32] is always clear between steps, so the sum fits 33 bits.
        sum_s     = acc_i + {1'b0, addend_s};
        shifted_s = {acc_i[31:0], sh_i[31]};
        diff_s    = {1'b0, shifted_s} - {2'b00, operand_i};

        if (is_div) begin
            if (diff_s[33]) begin
                // Trial subtract borrowed: restore, quotient bit 0.
                acc_o = shifted_s;
                sh_o  = {sh_i[30:0], 1'b0};
            end else begin
                acc_o = diff_s[32:0];
                sh_o  = {sh_i[30:0], 1'b1};
            end
        end else begin
            acc_o = {1'b0, sum_s[32:1]};
            sh_o  = {sum_s[0], sh_i[31:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take 33 cycles from the accepting edge to the HI/LO
// update; MTHI/MTLO write in a single cycle. A new operation may be
// accepted on the same edge that writes the previous result (FIX state).
module mult_div_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    muldiv_state_t state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          is_div_q, is_div_d;
    logic          sign_a_q, sign_a_d;
    logic          sign_b_q, sign_b_d;
    logic          b_zero_q, b_zero_d;
    logic [31:0]   operand_q, operand_d;
    logic [32:0]   acc_q, acc_d;
    logic [31:0]   sh_q, sh_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    muldiv_op_t    op_s;
    logic          can_start_s;
    logic          accept_s;
    logic          mthi_s;
    logic          mtlo_s;
    logic          op_signed_s;
    logic          in_sign_a_s;
    logic          in_sign_b_s;
    logic [32:0]   step_acc_s;
    logic [31:0]   step_sh_s;
    logic [63:0]   prod_s;
    logic [31:0]   quo_s;
    logic [31:0]   rem_s;
    logic [31:0]   res_hi_s;
    logic [31:0]   res_lo_s;

    muldiv_step u_step (
        .is_div    (is_div_q),
        .acc_i     (acc_q),
        .sh_i      (sh_q),
        .operand_i (operand_q),
        .acc_o     (step_acc_s),
        .sh_o      (step_sh_s)
    );

    // Decode the request: start is only honoured when not iterating.
    always_comb begin
        op_s        = muldiv_op_t'(op);
        can_start_s = start && (state_q != ITER);
        accept_s    = 1'b0;
        mthi_s      = 1'b0;
        mtlo_s      = 1'b0;
        op_signed_s = 1'b0;
        case (op_s)
            OP_MULT:  begin accept_s = can_start_s; op_signed_s = 1'b1; end
            OP_MULTU: begin accept_s = can_start_s; end
            OP_DIV:   begin accept_s = can_start_s; op_signed_s = 1'b1; end
            OP_DIVU:  begin accept_s = can_start_s; end
            OP_MTHI:  begin mthi_s = can_start_s; end
            OP_MTLO:  begin mtlo_s = can_start_s; end
            default:  begin accept_s = 1'b0; end
        endcase
        in_sign_a_s = op_signed_s & a[31];
        in_sign_b_s = op_signed_s & b[31];
    end

    // Next-state logic.
    always_comb begin
        case (state_q)
            IDLE, FIX: begin
                if (accept_s) begin
                    state_d = ITER;
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                if (cnt_q == MULDIV_LAST_ITER) begin
                    state_d = FIX;
                end else begin
                    state_d = ITER;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs, registered: busy while iterating, done after the FIX edge.
    always_comb begin
        busy_d = (state_d == ITER);
        done_d = (state_q == FIX);
    end

    // Operand latch on accept, one datapath step per ITER cycle.
    always_comb begin
        is_div_d  = is_div_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        b_zero_d  = b_zero_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        if (accept_s) begin
            is_div_d  = op[1];
            sign_a_d  = in_sign_a_s;
            sign_b_d  = in_sign_b_s;
            b_zero_d  = (b == 32'd0);
            sh_d      = cond_neg32(a, in_sign_a_s);
            operand_d = cond_neg32(b, in_sign_b_s);
            acc_d     = 33'd0;
            cnt_d     = 6'd0;
        end else if (state_q == ITER) begin
            acc_d = step_acc_s;
            sh_d  = step_sh_s;
            cnt_d = cnt_q + 6'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Sign fix-up of the magnitude result; division by zero forces LO to all ones.
    always_comb begin
        prod_s = cond_neg64({acc_q[31:0], sh_q}, sign_a_q ^ sign_b_q);
        quo_s  = cond_neg32(sh_q, sign_a_q ^ sign_b_q);
        rem_s  = cond_neg32(acc_q[31:0], sign_a_q);
        if (is_div_q) begin
            res_hi_s = rem_s;
            if (b_zero_q) begin
                res_lo_s = 32'hFFFF_FFFF;
            end else begin
                res_lo_s = quo_s;
            end
        end else begin
            res_hi_s = prod_s[63:32];
            res_lo_s = prod_s[31:0];
        end
    end

    // HI/LO update: result at the FIX edge; a same-edge MTHI/MTLO is younger and wins.
    always_comb begin
        if (mthi_s) begin
            hi_d = a;
        end else if (state_q == FIX) begin
            hi_d = res_hi_s;
        end else begin
            hi_d = hi_q;
        end
        if (mtlo_s) begin
            lo_d = a;
        end else if (state_q == FIX) begin
            lo_d = res_lo_s;
        end else begin
            lo_d = lo_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            is_div_q  <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            b_zero_q  <= 1'b0;
            operand_q <= 32'd0;
            acc_q     <= 33'd0;
            sh_q      <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            b_zero_q  <= b_zero_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
